load_use_scoreboard: RTL

Parametrised load-use hazard unit for the LC-3b pipeline, sitting beside the ID stage. A per-register countdown scoreboard tracks pending load destinations. When the instruction in ID reads a register whose load result is not yet forwardable, the unit stalls IF/ID and injects a bubble into EX. It supports configurable load latency and source count. Saturating, clearable counters record issued instructions, bubbles, and memory-freeze cycles.

---
 rtl/lc3b_types.sv | 13 +
 rtl/sat_counter.sv | 26 ++
 rtl/load_use_scoreboard.sv | 115 +++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b type definitions.
//   lc3b_reg    - architectural register index (R0..R7)
//   lc3b_pend_t - load-use countdown entry, wide enough for a load
//                 latency of up to LC3B_MAX_LOAD_LATENCY bubbles
package lc3b_types;

  localparam int LC3B_NUM_REGS         = 8;
  localparam int LC3B_MAX_LOAD_LATENCY = 7;

  typedef logic [2:0] lc3b_reg;
  typedef logic [2:0] lc3b_pend_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset, zeroes the count
//   clear - synchronous clear; wins over inc in the same cycle
//   inc   - add one this cycle (ignored once saturated)
//   count - current value
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/load_use_scoreboard.sv
// load_use_scoreboard: load-use hazard unit beside the LC-3b ID stage.
// Each register has a countdown entry that is loaded with LOAD_LATENCY when a
// load issues to it; while the entry is non-zero a reader in ID must wait.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   id_valid             - ID holds a real instruction
//   id_src, id_src_used  - packed source register numbers and their enables
//   id_dest, id_writes   - destination register and its write enable
//   id_is_load           - ID instruction is a load
//   mem_stall            - whole pipeline frozen this cycle
//   count_clear          - synchronous clear of the performance counters
//   stall, bubble        - hold PC/IF-ID, inject NOP into ID/EX
//   instr_count, bubble_count, freeze_count - saturating performance counters
//
// Handshake: stall and bubble are combinational in the cycle the dependent
// instruction sits in ID. stall holds while a hazard exists, even when the
// memory system freezes the pipe; bubble is only raised on cycles that
// actually advance (no mem_stall), so each bubble corresponds to one EX slot.
module load_use_scoreboard
  import lc3b_types::*;
#(
  parameter int NUM_REGS     = LC3B_NUM_REGS,
  parameter int NUM_SRC      = 2,
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_WIDTH    = 16,
  localparam int RW          = $clog2(NUM_REGS),
  localparam int PW          = $clog2(LOAD_LATENCY + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [NUM_SRC*RW-1:0]   id_src,
  input  logic [NUM_SRC-1:0]      id_src_used,
  input  logic [RW-1:0]           id_dest,
  input  logic                    id_writes,
  input  logic                    id_is_load,
  input  logic                    mem_stall,
  input  logic                    count_clear,
  output logic                    stall,
  output logic                    bubble,
  output logic [CNT_WIDTH-1:0]    instr_count,
  output logic [CNT_WIDTH-1:0]    bubble_count,
  output logic [CNT_WIDTH-1:0]    freeze_count
);

  localparam logic [PW-1:0] LAT = PW'(LOAD_LATENCY);

  logic [PW-1:0]      pend [NUM_REGS];
  logic [NUM_SRC-1:0] src_hit;
  logic               hazard;
  logic               issue;
  logic               set_load;
  logic               set_alu;

  // A source only matters when the decoder says the instruction reads it.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_hit[i] = id_src_used[i] & (pend[id_src[i*RW +: RW]] != '0);
  end

  assign hazard   = id_valid & (|src_hit);
  assign stall    = hazard;
  assign bubble   = hazard & ~mem_stall;
  assign issue    = id_valid & ~hazard & ~mem_stall;
  assign set_load = issue & id_writes & id_is_load;
  assign set_alu  = issue & id_writes & ~id_is_load;

  // One countdown per register. A self-sourcing load is not stalled because
  // its own entry is only written at the end of its issue cycle. A newer ALU
  // producer clears the entry since its result is covered by forwarding.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    localparam logic [RW-1:0] IDX = RW'(r);
    logic [PW-1:0] entry;

    always_ff @(posedge clk) begin
      if (reset) begin
        entry <= '0;
      end else if (!mem_stall) begin
        if (set_load && (id_dest == IDX)) begin
          entry <= LAT;
        end else if (set_alu && (id_dest == IDX)) begin
          entry <= '0;
        end else if (entry != '0) begin
          entry <= entry - PW'(1);
        end
      end
    end

    assign pend[r] = entry;
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (count_clear),
    .inc   (issue),
    .count (instr_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (count_clear),
    .inc   (bubble),
    .count (bubble_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_freeze_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (count_clear),
    .inc   (mem_stall),
    .count (freeze_count)
  );

endmodule
